cordic_result_buffer: RTL and testbench

Downstream stage of the hybrid CORDIC core. It detects each rising edge of the core's done flag and captures the cos/sin result pair into a DEPTH-entry FIFO. The FIFO presents the pairs to the consumer over a valid/ready interface, so a slow consumer does not lose results. Results that arrive while the FIFO is full are dropped, flagged and counted.

---
 rtl/cordic_result_buffer.sv | 93 +++++++++
 tb/tb_cordic_result_buffer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cordic_result_buffer.sv
// Captures each CORDIC cos/sin result on the rising edge of done_in into a
// first-word-fall-through FIFO; results arriving while full are dropped and counted.
module cordic_result_buffer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         cos_in,
    input  logic [WIDTH-1:0]         sin_in,
    input  logic                     done_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         cos_out,
    output logic [WIDTH-1:0]         sin_out,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_count,
    input  logic                     clear_ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q;
    logic               done_q;
    logic               overflow_q;
    logic [CNT_W-1:0]   drop_count_q;

    logic capture, full, pop, push, drop;

    always_comb begin
        capture = done_in & ~done_q;
        full    = (count_q == CW'(DEPTH));
        pop     = (count_q != '0) & out_ready;
        // A pop on a full FIFO frees the slot the incoming result needs.
        push    = capture & (~full | pop);
        drop    = capture & full & ~pop;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            done_q <= done_in;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);

            // A drop in the same cycle as a clear leaves the new drop recorded.
            if (drop) begin
                overflow_q <= 1'b1;
                if (clear_ovf) begin
                    drop_count_q <= CNT_W'(1);
                end else if (drop_count_q != '1) begin
                    drop_count_q <= drop_count_q + CNT_W'(1);
                end
            end else if (clear_ovf) begin
                overflow_q   <= 1'b0;
                drop_count_q <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {cos_in, sin_in};
        end
    end

    always_comb begin
        out_valid  = (count_q != '0);
        count      = count_q;
        overflow   = overflow_q;
        drop_count = drop_count_q;
        // Gate the head so the outputs read zero whenever nothing is held.
        cos_out    = out_valid ? mem[rd_ptr_q][2*WIDTH-1:WIDTH] : '0;
        sin_out    = out_valid ? mem[rd_ptr_q][WIDTH-1:0]       : '0;
    end

endmodule

// File: tb/tb_cordic_result_buffer.sv
// Bench for cordic_result_buffer: directed vector table, hand-written corner
// sequences and random traffic checked against a queue-based reference model.
module tb_cordic_result_buffer;

    localparam int W = 32;
    localparam int D = 8;
    localparam int C = 16;
    localparam int MAXD = (1 << C) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   cos_in, sin_in;
    logic           done_in;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   cos_out, sin_out;
    logic [$clog2(D):0] count;
    logic           overflow;
    logic [C-1:0]   drop_count;
    logic           clear_ovf;

    cordic_result_buffer #(.WIDTH(W), .DEPTH(D), .CNT_W(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .cos_in     (cos_in),
        .sin_in     (sin_in),
        .done_in    (done_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .cos_out    (cos_out),
        .sin_out    (sin_out),
        .count      (count),
        .overflow   (overflow),
        .drop_count (drop_count),
        .clear_ovf  (clear_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: queue of {cos,sin} pairs plus sticky flag and drop tally.
    logic [2*W-1:0] mq[$];
    logic           m_prev = 1'b0;
    logic           m_ovf = 1'b0;
    int             m_drop = 0;

    typedef struct {
        logic         done;
        logic         ready;
        logic [W-1:0] cv;
        logic [W-1:0] sv;
        logic         ev;
        logic [W-1:0] ecos;
        logic [W-1:0] esin;
        int           ecnt;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic check_model();
        logic [2*W-1:0] head;
        logic ok;
        head = (mq.size() != 0) ? mq[0] : '0;
        ok = (out_valid === (mq.size() != 0)) && (count === ($clog2(D)+1)'(mq.size()))
            && (overflow === m_ovf) && (drop_count === C'(m_drop));
        if (mq.size() != 0) ok = ok && ({cos_out, sin_out} === head);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL model cyc=%0d actual v=%b n=%0d ovf=%b drop=%0d cos=%h sin=%h expected v=%b n=%0d ovf=%b drop=%0d head=%h",
                     cyc, out_valid, count, overflow, drop_count, cos_out, sin_out,
                     mq.size() != 0, mq.size(), m_ovf, m_drop, head);
        end
    endtask

    task automatic cycle(input logic d, input logic r, input logic c,
                         input logic [W-1:0] cv, input logic [W-1:0] sv);
        bit pop, cap, acc;
        done_in = d; out_ready = r; clear_ovf = c; cos_in = cv; sin_in = sv;
        pop = (mq.size() != 0) && r;
        cap = d && !m_prev;
        acc = (mq.size() < D) || pop;
        m_prev = d;
        if (c) begin
            m_ovf = 1'b0;
            m_drop = 0;
        end
        if (pop) void'(mq.pop_front());
        if (cap && acc) mq.push_back({cv, sv});
        if (cap && !acc) begin
            m_ovf = 1'b1;
            m_drop = (m_drop == MAXD) ? MAXD : m_drop + 1;
        end
        @(posedge clk);
        #1;
        cyc++;
        check_model();
    endtask

    task automatic model_reset();
        mq.delete();
        m_prev = 1'b0;
        m_ovf = 1'b0;
        m_drop = 0;
    endtask

    task automatic pulse(input logic r, input logic [W-1:0] cv, input logic [W-1:0] sv);
        cycle(1'b1, r, 1'b0, cv, sv);
        cycle(1'b0, r, 1'b0, '0, '0);
    endtask

    logic [W-1:0] drain_exp[8];
    int rp;

    initial begin
        rst = 1'b0;
        done_in = 1'b0; out_ready = 1'b0; clear_ovf = 1'b0; cos_in = '0; sin_in = '0;

        tbl[0] = '{1'b0, 1'b1, 32'h0,        32'h0,  1'b0, 32'h0,        32'h0,  0};
        tbl[1] = '{1'b1, 1'b1, 32'h40000000, 32'h0,  1'b1, 32'h40000000, 32'h0,  1};
        tbl[2] = '{1'b0, 1'b1, 32'h0,        32'h0,  1'b0, 32'h0,        32'h0,  0};
        tbl[3] = '{1'b1, 1'b0, 32'h11,       32'h22, 1'b1, 32'h11,       32'h22, 1};
        tbl[4] = '{1'b1, 1'b0, 32'h33,       32'h44, 1'b1, 32'h11,       32'h22, 1};
        tbl[5] = '{1'b1, 1'b1, 32'h55,       32'h66, 1'b0, 32'h0,        32'h0,  0};
        tbl[6] = '{1'b1, 1'b1, 32'h77,       32'h88, 1'b0, 32'h0,        32'h0,  0};
        tbl[7] = '{1'b0, 1'b1, 32'h99,       32'haa, 1'b0, 32'h0,        32'h0,  0};

        #12;
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_ovf", 64'(overflow), 64'd0);
        chk("reset_drop", 64'(drop_count), 64'd0);
        chk("reset_data", {cos_out, sin_out}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single result, then done held high over changing data.
        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].done, tbl[i].ready, 1'b0, tbl[i].cv, tbl[i].sv);
            chk("tbl_valid", 64'(out_valid), 64'(tbl[i].ev));
            chk("tbl_count", 64'(count), 64'(tbl[i].ecnt));
            if (tbl[i].ev) chk("tbl_data", {cos_out, sin_out}, {tbl[i].ecos, tbl[i].esin});
        end

        // Fill past capacity with the consumer stalled.
        for (int i = 1; i <= 10; i++) pulse(1'b0, W'(i), W'(i) ^ 32'hffff0000);
        chk("fill_count", 64'(count), 64'd8);
        chk("fill_ovf", 64'(overflow), 64'd1);
        chk("fill_drop", 64'(drop_count), 64'd2);
        chk("fill_head", 64'(cos_out), 64'd1);

        cycle(1'b0, 1'b0, 1'b1, '0, '0);
        chk("clr_ovf", 64'(overflow), 64'd0);
        chk("clr_drop", 64'(drop_count), 64'd0);
        chk("clr_count", 64'(count), 64'd8);

        // Capture while full but popping: accepted, no drop.
        cycle(1'b1, 1'b1, 1'b0, 32'd100, 32'd101);
        chk("fullpop_count", 64'(count), 64'd8);
        chk("fullpop_ovf", 64'(overflow), 64'd0);
        chk("fullpop_head", 64'(cos_out), 64'd2);
        cycle(1'b0, 1'b0, 1'b0, '0, '0);

        // Drop coinciding with clear: drop wins.
        cycle(1'b1, 1'b0, 1'b1, 32'd200, 32'd201);
        chk("clrdrop_ovf", 64'(overflow), 64'd1);
        chk("clrdrop_drop", 64'(drop_count), 64'd1);
        cycle(1'b0, 1'b0, 1'b0, '0, '0);

        drain_exp = '{32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd100};
        for (int i = 0; i < 8; i++) begin
            chk("drain_data", 64'(cos_out), 64'(drain_exp[i]));
            cycle(1'b0, 1'b1, 1'b0, '0, '0);
        end
        chk("drain_empty", 64'(out_valid), 64'd0);

        // Asynchronous reset with five entries pending.
        for (int i = 0; i < 5; i++) pulse(1'b0, W'(32'h500 + i), W'(i));
        chk("prerst_count", 64'(count), 64'd5);
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        pulse(1'b0, 32'habcd1234, 32'h5678ef01);
        chk("postrst_count", 64'(count), 64'd1);
        chk("postrst_data", {cos_out, sin_out}, 64'habcd1234_5678ef01);
        cycle(1'b0, 1'b1, 1'b0, '0, '0);

        // Random traffic with varying consumer throughput.
        for (int i = 0; i < 800; i++) begin
            if (i % 100 == 0) rp = $urandom_range(5, 95);
            cycle($urandom_range(0, 2) == 0, $urandom_range(0, 99) < rp,
                  $urandom_range(0, 39) == 0, $urandom, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
